// File: rtl/three_phase_spwm_if.sv
// Bus between the three-phase sine generator side and the SPWM block.
// master: drives run enable and the three modulating waves, observes gates/sync/carrier.
// slave : the SPWM block itself.
//   en             run enable
//   mod_a/b/c      signed modulating waves, W bits
//   gate_hi/lo     [0]=A [1]=B [2]=C, active high
//   sync           one-cycle pulse at the carrier valley
//   carrier        current signed carrier value
interface three_phase_spwm_if #(
    parameter int W = 12
);
    logic                en;
    logic signed [W-1:0] mod_a;
    logic signed [W-1:0] mod_b;
    logic signed [W-1:0] mod_c;
    logic [2:0]          gate_hi;
    logic [2:0]          gate_lo;
    logic                sync;
    logic signed [W-1:0] carrier;

    modport master (
        output en, mod_a, mod_b, mod_c,
        input  gate_hi, gate_lo, sync, carrier
    );

    modport slave (
        input  en, mod_a, mod_b, mod_c,
        output gate_hi, gate_lo, sync, carrier
    );
endinterface

// File: rtl/three_phase_spwm.sv
// Three-phase sinusoidal PWM with dead-time.
// A symmetric triangular carrier (-P..+P, period 4*P clocks) is compared with
// three signed modulating waves latched once per period at the valley. Each
// leg drives a complementary high/low gate pair through a small FSM that
// inserts DEADTIME both-off cycles before any gate turns on.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   bus         three_phase_spwm_if.slave (en, mod_a/b/c in; gate_hi/lo, sync, carrier out)

// One inverter leg: turns the registered compare result into a gate pair.
module spwm_leg #(
    parameter int DEADTIME = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic raw,
    output logic gate_hi,
    output logic gate_lo
);
    typedef enum logic [2:0] {OFF, HI_ON, LO_ON, DT_TO_HI, DT_TO_LO} state_e;

    localparam logic [7:0] CNT_LOAD = 8'(DEADTIME - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       gate_hi_q, gate_hi_d;
    logic       gate_lo_q, gate_lo_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!en) begin
            state_d = OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                OFF: begin
                    state_d = raw ? DT_TO_HI : DT_TO_LO;
                    cnt_d   = CNT_LOAD;
                end
                // A reversal of the target restarts the full dead-time,
                // so it is checked before the count expiring.
                DT_TO_HI: begin
                    if (!raw) begin
                        state_d = DT_TO_LO;
                        cnt_d   = CNT_LOAD;
                    end else if (cnt_q == 8'd0) begin
                        state_d = HI_ON;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                DT_TO_LO: begin
                    if (raw) begin
                        state_d = DT_TO_HI;
                        cnt_d   = CNT_LOAD;
                    end else if (cnt_q == 8'd0) begin
                        state_d = LO_ON;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                HI_ON: begin
                    if (!raw) begin
                        state_d = DT_TO_LO;
                        cnt_d   = CNT_LOAD;
                    end
                end
                LO_ON: begin
                    if (raw) begin
                        state_d = DT_TO_HI;
                        cnt_d   = CNT_LOAD;
                    end
                end
                default: state_d = OFF;
            endcase
        end
        // Gates decoded from the next state so they are glitch-free flops
        // aligned with the state register.
        gate_hi_d = (state_d == HI_ON);
        gate_lo_d = (state_d == LO_ON);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= OFF;
            cnt_q     <= '0;
            gate_hi_q <= 1'b0;
            gate_lo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gate_hi_q <= gate_hi_d;
            gate_lo_q <= gate_lo_d;
        end
    end

    assign gate_hi = gate_hi_q;
    assign gate_lo = gate_lo_q;
endmodule

module three_phase_spwm #(
    parameter int W            = 12,
    parameter int CARRIER_PEAK = 2047,
    parameter int DEADTIME     = 50
) (
    input logic                  clk,
    input logic                  rst_n,
    three_phase_spwm_if.slave    bus
);
    localparam logic signed [W-1:0] P      = W'(CARRIER_PEAK);
    localparam logic signed [W-1:0] P_M1   = W'(CARRIER_PEAK - 1);
    localparam logic signed [W-1:0] NEG_P  = W'(-CARRIER_PEAK);
    localparam logic signed [W-1:0] NEG_P1 = W'(1 - CARRIER_PEAK);
    localparam logic signed [W-1:0] ONE    = W'(1);

    logic signed [W-1:0] carrier_q, carrier_d;
    logic                dir_up_q, dir_up_d;
    logic [2:0][W-1:0]   shadow_q, shadow_d;
    logic [2:0]          raw_q, raw_d;
    logic [2:0][W-1:0]   mod_v;
    logic [2:0]          gate_hi_w, gate_lo_w;
    logic                at_valley;

    // Saturated compare: inputs at or beyond the carrier peaks pin the leg,
    // so a full-scale wave never produces a one-clock sliver at the apex.
    function automatic logic cmp_leg(input logic signed [W-1:0] sh,
                                     input logic signed [W-1:0] car);
        if (sh >= P)
            return 1'b1;
        else if (sh <= NEG_P)
            return 1'b0;
        return sh > car;
    endfunction

    assign mod_v     = {bus.mod_c, bus.mod_b, bus.mod_a};
    assign at_valley = (carrier_q == NEG_P);

    always_comb begin
        carrier_d = carrier_q;
        dir_up_d  = dir_up_q;
        shadow_d  = shadow_q;
        if (!bus.en) begin
            carrier_d = NEG_P;
            dir_up_d  = 1'b1;
        end else if (dir_up_q) begin
            if (carrier_q == P) begin
                carrier_d = P_M1;
                dir_up_d  = 1'b0;
            end else begin
                carrier_d = carrier_q + ONE;
            end
        end else begin
            // -P is visited once, as the first value of the next up-ramp.
            if (carrier_q == NEG_P1)
                dir_up_d = 1'b1;
            carrier_d = carrier_q - ONE;
        end
        // Latching only at the valley keeps each period's duty self-consistent
        // despite the generator updating the three phases at different times.
        if (!bus.en || at_valley)
            shadow_d = mod_v;
        for (int i = 0; i < 3; i++)
            raw_d[i] = cmp_leg(shadow_q[i], carrier_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carrier_q <= NEG_P;
            dir_up_q  <= 1'b1;
            shadow_q  <= '0;
            raw_q     <= '0;
        end else begin
            carrier_q <= carrier_d;
            dir_up_q  <= dir_up_d;
            shadow_q  <= shadow_d;
            raw_q     <= raw_d;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_leg
        spwm_leg #(.DEADTIME(DEADTIME)) u_leg (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (bus.en),
            .raw     (raw_q[i]),
            .gate_hi (gate_hi_w[i]),
            .gate_lo (gate_lo_w[i])
        );
    end

    assign bus.gate_hi = gate_hi_w;
    assign bus.gate_lo = gate_lo_w;
    assign bus.carrier = carrier_q;
    // Qualified by rst_n so a held reset shows an all-zero output set.
    assign bus.sync    = rst_n && bus.en && at_valley;
endmodule
